// File: rtl/mpe_pkg.sv
// Shared types and constants for the matrix_pe_v2 dot-product engine.
// Holds the FSM encoding, the uop field layout and the adder-tree width helper.
package mpe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mpe_state_e;

  localparam int UOP_CNT_LSB = 0;

  // Saturate flag sits directly above the beat-count field
  function automatic int uop_sat_bit(input int iter_w);
    return UOP_CNT_LSB + iter_w;
  endfunction

  // Exact width of a LANES-wide sum of DATA_W x DATA_W signed products
  function automatic int tree_w(input int lanes, input int data_w);
    return 2 * data_w + $clog2(lanes);
  endfunction

  localparam int UOP_SAT_BIT = uop_sat_bit(8);
  localparam int TREE_W      = tree_w(32, 16);

endpackage

// File: rtl/mpe_mac_tree.sv
// Two-stage multiply/reduce pipe: stage 1 registers lane products,
// stage 2 registers their full-precision sum. A valid bit travels alongside.
module mpe_mac_tree
  import mpe_pkg::*;
#(
  parameter int LANES  = 32,
  parameter int DATA_W = 16,
  parameter int SUM_W  = tree_w(LANES, DATA_W)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_vld,
  input  logic [LANES*DATA_W-1:0]    neuron,
  input  logic [LANES*DATA_W-1:0]    weight,
  output logic signed [SUM_W-1:0]    sum_q,
  output logic                       sum_vld,
  output logic                       busy
);

  logic signed [2*DATA_W-1:0] prod_q [LANES];
  logic                       prod_vld;
  logic signed [SUM_W-1:0]    tree_sum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_vld <= 1'b0;
      sum_vld  <= 1'b0;
      sum_q    <= '0;
    end else begin
      prod_vld <= in_vld;
      sum_vld  <= prod_vld;
      if (in_vld) begin
        for (int i = 0; i < LANES; i++) begin
          prod_q[i] <= $signed(neuron[i*DATA_W +: DATA_W]) * $signed(weight[i*DATA_W +: DATA_W]);
        end
      end
      if (prod_vld) sum_q <= tree_sum;
    end
  end

  // Sized casts sign-extend each product so the sum never loses precision
  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      tree_sum = tree_sum + SUM_W'(prod_q[i]);
    end
  end

  assign busy = prod_vld | sum_vld;

endmodule

// File: rtl/matrix_pe_v2.sv
// LANES-wide signed dot-product engine: one uop, N paired neuron/weight beats,
// one accumulated result (wrapping or saturating) on a valid/ready port.
//
// Handshakes: every port transfers on a rising edge where its valid and ready
// are both high; a source keeps data stable while valid is high and not ready.
module matrix_pe_v2
  import mpe_pkg::*;
#(
  parameter int LANES  = 32,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int ITER_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ITER_W:0]         ib_ctl_uop,
  input  logic                    ib_ctl_uop_valid,
  output logic                    ib_ctl_uop_ready,
  input  logic [LANES*DATA_W-1:0] nram_mpe_neuron,
  input  logic                    nram_mpe_neuron_valid,
  output logic                    nram_mpe_neuron_ready,
  input  logic [LANES*DATA_W-1:0] wram_mpe_weight,
  input  logic                    wram_mpe_weight_valid,
  output logic                    wram_mpe_weight_ready,
  output logic [ACC_W-1:0]        result,
  output logic                    result_ovf,
  output logic                    vld_o,
  input  logic                    result_ready,
  output mpe_state_e              dbg_state
);

  localparam int TW      = tree_w(LANES, DATA_W);
  localparam int EW      = ((TW > ACC_W) ? TW : ACC_W) + 1;
  localparam int SAT_BIT = uop_sat_bit(ITER_W);

  mpe_state_e               state_q, state_d;
  logic [ITER_W-1:0]        cnt_q, n_q;
  logic                     sat_q;
  logic signed [ACC_W-1:0]  acc_q, acc_next;
  logic                     ovf_q;

  logic                     uop_fire, beat_pair, beat_fire, last_beat;
  logic [ITER_W:0]          cnt_inc;
  logic [ITER_W-1:0]        uop_n;
  logic signed [TW-1:0]     tree_sum;
  logic                     tree_vld, tree_busy;
  logic signed [EW-1:0]     sum_ext;
  logic                     in_range;

  assign uop_n     = ib_ctl_uop[UOP_CNT_LSB +: ITER_W];
  assign uop_fire  = ib_ctl_uop_valid & ib_ctl_uop_ready;
  assign beat_pair = nram_mpe_neuron_valid & wram_mpe_weight_valid;
  assign beat_fire = (state_q == RUN) & beat_pair;
  assign cnt_inc   = {1'b0, cnt_q} + {{ITER_W{1'b0}}, 1'b1};
  assign last_beat = beat_fire & (cnt_inc == {1'b0, n_q});

  mpe_mac_tree #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .SUM_W  (TW)
  ) u_tree (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (beat_fire),
    .neuron  (nram_mpe_neuron),
    .weight  (wram_mpe_weight),
    .sum_q   (tree_sum),
    .sum_vld (tree_vld),
    .busy    (tree_busy)
  );

  // Exact sum is wide enough to never overflow; range test picks wrap vs clamp
  assign sum_ext  = EW'(acc_q) + EW'(tree_sum);
  assign in_range = (sum_ext[EW-1:ACC_W-1] == {(EW-ACC_W+1){sum_ext[ACC_W-1]}});

  always_comb begin
    acc_next = sum_ext[ACC_W-1:0];
    if (!in_range && sat_q) begin
      acc_next = sum_ext[EW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_comb begin
    state_d               = state_q;
    ib_ctl_uop_ready      = 1'b0;
    nram_mpe_neuron_ready = 1'b0;
    wram_mpe_weight_ready = 1'b0;
    vld_o                 = 1'b0;
    unique case (state_q)
      IDLE: begin
        ib_ctl_uop_ready = 1'b1;
        if (ib_ctl_uop_valid) state_d = (uop_n == '0) ? DONE : RUN;
      end
      RUN: begin
        nram_mpe_neuron_ready = beat_pair;
        wram_mpe_weight_ready = beat_pair;
        if (last_beat) state_d = DRAIN;
      end
      DRAIN: begin
        if (!tree_busy) state_d = DONE;
      end
      DONE: begin
        vld_o = 1'b1;
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      sat_q   <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (uop_fire) begin
        n_q   <= uop_n;
        sat_q <= ib_ctl_uop[SAT_BIT];
        cnt_q <= '0;
        acc_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        if (beat_fire) cnt_q <= cnt_inc[ITER_W-1:0];
        if (tree_vld) begin
          acc_q <= acc_next;
          if (!in_range) ovf_q <= 1'b1;
        end
      end
    end
  end

  assign result     = acc_q;
  assign result_ovf = ovf_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_matrix_pe_v2.sv
// Bench for matrix_pe_v2: directed vector table, multi-cycle corner sequences,
// and randomized ops scored against a plain-arithmetic dot-product model.
module tb_matrix_pe_v2;
  import mpe_pkg::*;

  localparam int LANES  = 32;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;
  localparam int ITER_W = 8;
  localparam int BW     = LANES * DATA_W;
  localparam longint AMAX = 64'sd2147483647;
  localparam longint AMIN = -64'sd2147483648;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ITER_W:0]   ib_ctl_uop = '0;
  logic              ib_ctl_uop_valid = 1'b0;
  logic              ib_ctl_uop_ready;
  logic [BW-1:0]     nram_mpe_neuron = '0;
  logic              nram_mpe_neuron_valid = 1'b0;
  logic              nram_mpe_neuron_ready;
  logic [BW-1:0]     wram_mpe_weight = '0;
  logic              wram_mpe_weight_valid = 1'b0;
  logic              wram_mpe_weight_ready;
  logic [ACC_W-1:0]  result;
  logic              result_ovf;
  logic              vld_o;
  logic              result_ready = 1'b1;
  mpe_state_e        dbg_state;

  matrix_pe_v2 #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .ITER_W(ITER_W)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .ib_ctl_uop            (ib_ctl_uop),
    .ib_ctl_uop_valid      (ib_ctl_uop_valid),
    .ib_ctl_uop_ready      (ib_ctl_uop_ready),
    .nram_mpe_neuron       (nram_mpe_neuron),
    .nram_mpe_neuron_valid (nram_mpe_neuron_valid),
    .nram_mpe_neuron_ready (nram_mpe_neuron_ready),
    .wram_mpe_weight       (wram_mpe_weight),
    .wram_mpe_weight_valid (wram_mpe_weight_valid),
    .wram_mpe_weight_ready (wram_mpe_weight_ready),
    .result                (result),
    .result_ovf            (result_ovf),
    .vld_o                 (vld_o),
    .result_ready          (result_ready),
    .dbg_state             (dbg_state)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [BW-1:0] nb [256];
  logic [BW-1:0] wb [256];

  typedef struct {
    int          n;
    bit          sat;
    int          mode;     // 0: every lane gets nv/wv, 1: lane 0 only
    logic [15:0] nv;
    logic [15:0] wv;
    bit          randv;
    logic [31:0] exp_res;
    bit          exp_ovf;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill(input int idx, input int mode, input logic [15:0] nv, input logic [15:0] wv);
    nb[idx] = '0;
    wb[idx] = '0;
    for (int l = 0; l < LANES; l++) begin
      if (mode == 0 || l == 0) begin
        nb[idx][l*DATA_W +: DATA_W] = nv;
        wb[idx][l*DATA_W +: DATA_W] = wv;
      end
    end
  endtask

  // Reference: exact integer dot products, then wrap or clamp per accumulate step
  task automatic model(input int n, input bit sat, output logic [31:0] r, output bit ovf);
    longint acc = 0;
    longint s, t;
    ovf = 1'b0;
    for (int b = 0; b < n; b++) begin
      s = 0;
      for (int l = 0; l < LANES; l++) begin
        s += longint'($signed(nb[b][l*DATA_W +: DATA_W])) * longint'($signed(wb[b][l*DATA_W +: DATA_W]));
      end
      t = acc + s;
      if (t > AMAX || t < AMIN) begin
        ovf = 1'b1;
        if (sat) t = (t > 0) ? AMAX : AMIN;
      end
      acc = longint'(int'(t));
    end
    r = acc[31:0];
  endtask

  // Called at a falling edge; returns at the falling edge after the uop handshake
  task automatic start_op(input int n, input bit sat);
    int k = 0;
    ib_ctl_uop       = {sat, n[ITER_W-1:0]};
    ib_ctl_uop_valid = 1'b1;
    #1;
    while (!ib_ctl_uop_ready && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (k >= 50) check("uop_accept_timeout", 0, 1);
    @(negedge clk);
    ib_ctl_uop_valid = 1'b0;
    ib_ctl_uop       = '0;
  endtask

  // Feeds n beats, then waits for vld_o; lat counts falling edges after the last handshake
  task automatic run_beats(input int n, input bit randv, output logic [31:0] res,
                           output bit ovf, output int lat, output bit rule_ok);
    int  i = 0;
    int  guard = 0;
    bit  fire;
    rule_ok = 1'b1;
    while (i < n && guard < 5000) begin
      nram_mpe_neuron_valid = randv ? 1'($urandom_range(0, 1)) : 1'b1;
      wram_mpe_weight_valid = randv ? 1'($urandom_range(0, 1)) : 1'b1;
      nram_mpe_neuron = nb[i];
      wram_mpe_weight = wb[i];
      #1;
      fire = nram_mpe_neuron_valid & wram_mpe_weight_valid;
      if (nram_mpe_neuron_ready !== fire || wram_mpe_weight_ready !== fire) rule_ok = 1'b0;
      @(negedge clk);
      if (fire) i++;
      guard++;
    end
    if (i < n) check("beat_feed_timeout", i, n);
    // Keep offering garbage beats: nothing more may be consumed
    nram_mpe_neuron_valid = 1'b1;
    wram_mpe_weight_valid = 1'b1;
    nram_mpe_neuron = {LANES{16'h7fff}};
    wram_mpe_weight = {LANES{16'h7fff}};
    lat = 0;
    while (!vld_o && lat < 20) begin
      #1;
      if (nram_mpe_neuron_ready !== 1'b0 || wram_mpe_weight_ready !== 1'b0) rule_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (nram_mpe_neuron_ready !== 1'b0 || wram_mpe_weight_ready !== 1'b0) rule_ok = 1'b0;
    nram_mpe_neuron_valid = 1'b0;
    wram_mpe_weight_valid = 1'b0;
    res = result;
    ovf = result_ovf;
  endtask

  task automatic consume(input string name);
    @(negedge clk);
    check({name, "_vld_width"}, vld_o, 0);
    check({name, "_uop_ready"}, ib_ctl_uop_ready, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res, mres, hold_res;
    bit          ovf, movf, rule_ok, stable;
    int          lat, n;
    bit          sat;

    vecs[0] = '{n:4, sat:1'b0, mode:0, nv:16'd1,     wv:16'd2,     randv:1'b0, exp_res:32'd256,        exp_ovf:1'b0};
    vecs[1] = '{n:0, sat:1'b0, mode:0, nv:16'd0,     wv:16'd0,     randv:1'b0, exp_res:32'd0,          exp_ovf:1'b0};
    vecs[2] = '{n:2, sat:1'b0, mode:1, nv:16'hfffd,  wv:16'd7,     randv:1'b1, exp_res:32'hffffffd6,   exp_ovf:1'b0};
    vecs[3] = '{n:3, sat:1'b1, mode:0, nv:16'h7fff,  wv:16'h7fff,  randv:1'b0, exp_res:32'h7fffffff,   exp_ovf:1'b1};
    vecs[4] = '{n:3, sat:1'b0, mode:0, nv:16'h7fff,  wv:16'h7fff,  randv:1'b0, exp_res:32'hffa00060,   exp_ovf:1'b1};
    vecs[5] = '{n:2, sat:1'b1, mode:0, nv:16'h8000,  wv:16'h7fff,  randv:1'b0, exp_res:32'h80000000,   exp_ovf:1'b1};
    vecs[6] = '{n:1, sat:1'b0, mode:0, nv:16'hffff,  wv:16'd1,     randv:1'b1, exp_res:32'hffffffe0,   exp_ovf:1'b0};

    // Reset
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_result", result, 0);
    check("rst_ovf", result_ovf, 0);
    check("rst_vld", vld_o, 0);
    check("rst_state", dbg_state, IDLE);
    check("rst_uop_ready", ib_ctl_uop_ready, 1);
    @(negedge clk);

    // Directed table
    for (int v = 0; v < 7; v++) begin
      for (int b = 0; b < vecs[v].n; b++) fill(b, vecs[v].mode, vecs[v].nv, vecs[v].wv);
      start_op(vecs[v].n, vecs[v].sat);
      run_beats(vecs[v].n, vecs[v].randv, res, ovf, lat, rule_ok);
      check($sformatf("vec%0d_result", v), res, vecs[v].exp_res);
      check($sformatf("vec%0d_ovf", v), ovf, vecs[v].exp_ovf);
      check($sformatf("vec%0d_latency", v), lat, (vecs[v].n == 0) ? 0 : 3);
      check($sformatf("vec%0d_ready_rule", v), rule_ok, 1);
      consume($sformatf("vec%0d", v));
    end

    // Randomized ops against the model, including the maximum beat count
    for (int r = 0; r < 10; r++) begin
      n   = (r == 9) ? 255 : $urandom_range(1, 12);
      sat = 1'($urandom_range(0, 1));
      for (int b = 0; b < n; b++) begin
        for (int l = 0; l < LANES; l++) begin
          nb[b][l*DATA_W +: DATA_W] = (r % 2 == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 200)) - 100);
          wb[b][l*DATA_W +: DATA_W] = (r % 2 == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 200)) - 100);
        end
      end
      model(n, sat, mres, movf);
      start_op(n, sat);
      run_beats(n, (r != 9), res, ovf, lat, rule_ok);
      check($sformatf("rand%0d_result", r), res, mres);
      check($sformatf("rand%0d_ovf", r), ovf, movf);
      check($sformatf("rand%0d_latency", r), lat, 3);
      check($sformatf("rand%0d_ready_rule", r), rule_ok, 1);
      consume($sformatf("rand%0d", r));
    end

    // Backpressure: result held, queued uop refused until IDLE
    fill(0, 0, 16'd1, 16'd1);
    result_ready = 1'b0;
    start_op(1, 1'b0);
    run_beats(1, 1'b0, res, ovf, lat, rule_ok);
    hold_res = res;
    check("hold_result", res, 32);
    ib_ctl_uop       = {1'b0, 8'd1};
    ib_ctl_uop_valid = 1'b1;
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (vld_o !== 1'b1 || result !== hold_res || ib_ctl_uop_ready !== 1'b0 || dbg_state !== DONE) stable = 1'b0;
      @(negedge clk);
    end
    check("hold_stable", stable, 1);
    result_ready = 1'b1;
    @(negedge clk);
    check("release_idle", dbg_state, IDLE);
    check("release_uop_ready", ib_ctl_uop_ready, 1);
    @(negedge clk);
    ib_ctl_uop_valid = 1'b0;
    check("queued_uop_taken", dbg_state, RUN);
    run_beats(1, 1'b0, res, ovf, lat, rule_ok);
    check("queued_result", res, 32);
    consume("queued");

    // Reset in RUN after 2 of 5 beats abandons the op
    for (int b = 0; b < 5; b++) fill(b, 0, 16'd3, 16'd5);
    start_op(5, 1'b0);
    for (int b = 0; b < 2; b++) begin
      nram_mpe_neuron_valid = 1'b1;
      wram_mpe_weight_valid = 1'b1;
      nram_mpe_neuron = nb[b];
      wram_mpe_weight = wb[b];
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_result", result, 0);
    check("midrst_ovf", result_ovf, 0);
    check("midrst_vld", vld_o, 0);
    check("midrst_state", dbg_state, IDLE);
    check("midrst_in_ready", {nram_mpe_neuron_ready, wram_mpe_weight_ready}, 0);
    nram_mpe_neuron_valid = 1'b0;
    wram_mpe_weight_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_flushed", result, 0);
    fill(0, 0, 16'd1, 16'd1);
    start_op(1, 1'b0);
    run_beats(1, 1'b0, res, ovf, lat, rule_ok);
    check("post_rst_result", res, 32);
    check("post_rst_ovf", ovf, 0);
    consume("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
